// File: rtl/sram_arbiter.sv
// Two-port arbiter/sequencer for the shared 16-bit async SRAM.
// Port 0 (audio) has priority; port 1 (loader) is forced through after MAX_WAIT waiting cycles.
`timescale 1ns/1ps
module sram_arbiter #(
   parameter int unsigned ADDR_W        = 20,
   parameter int unsigned ACCESS_CYCLES = 2,
   parameter int unsigned MAX_WAIT      = 16
) (
   input  logic              Clk,
   input  logic              reset_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [15:0]       wdata0,
   input  logic [1:0]        be0,
   output logic              ack0,
   output logic [15:0]       rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [15:0]       wdata1,
   input  logic [1:0]        be1,
   output logic              ack1,
   output logic [15:0]       rdata1,
   input  logic [15:0]       sram_rdata,
   output logic [15:0]       sram_wdata,
   output logic              sram_drive,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic              SRAM_CE_N,
   output logic              SRAM_OE_N,
   output logic              SRAM_WE_N,
   output logic              SRAM_UB_N,
   output logic              SRAM_LB_N
);

   localparam int unsigned CNT_W  = 3;
   localparam int unsigned WAIT_W = 8;
   localparam logic [CNT_W-1:0]  ACC_LAST = CNT_W'(ACCESS_CYCLES);
   localparam logic [CNT_W-1:0]  ACC_ONE  = CNT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   acc_cnt;
   logic [WAIT_W-1:0]  wait_cnt;
   logic               port_q;
   logic               we_q;

   logic               starve_c;
   logic               grant1_c;
   logic               grant_c;
   logic               sel_we_c;
   logic [ADDR_W-1:0]  sel_addr_c;
   logic [15:0]        sel_wdata_c;
   logic [1:0]         sel_be_c;

   // Arbitration decision and selected request fields for the IDLE cycle
   always_comb begin
      starve_c    = (wait_cnt >= WAIT_LIM);
      grant1_c    = req1 && (!req0 || starve_c);
      grant_c     = req0 || req1;
      sel_we_c    = grant1_c ? we1    : we0;
      sel_addr_c  = grant1_c ? addr1  : addr0;
      sel_wdata_c = grant1_c ? wdata1 : wdata0;
      sel_be_c    = grant1_c ? be1    : be0;
   end

   // Port 1 starvation counter: counts cycles port 1 waits while not being served
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= '0;
      end else if (!req1) begin
         wait_cnt <= '0;
      end else if (state == IDLE && grant1_c) begin
         wait_cnt <= '0;
      end else if ((state == IDLE || !port_q) && wait_cnt != WAIT_SAT) begin
         wait_cnt <= wait_cnt + WAIT_W'(1);
      end
   end

   // Access sequencer; SRAM pins are registered as the values for the coming cycle
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         acc_cnt    <= '0;
         port_q     <= 1'b0;
         we_q       <= 1'b0;
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         rdata0     <= '0;
         rdata1     <= '0;
         sram_wdata <= '0;
         sram_drive <= 1'b0;
         SRAM_ADDR  <= '0;
         SRAM_CE_N  <= 1'b1;
         SRAM_OE_N  <= 1'b1;
         SRAM_WE_N  <= 1'b1;
         SRAM_UB_N  <= 1'b1;
         SRAM_LB_N  <= 1'b1;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_c) begin
                  state     <= ACCESS;
                  acc_cnt   <= ACC_ONE;
                  port_q    <= grant1_c;
                  we_q      <= sel_we_c;
                  SRAM_ADDR <= sel_addr_c;
                  SRAM_CE_N <= 1'b0;
                  if (sel_we_c) begin
                     SRAM_OE_N  <= 1'b1;
                     sram_drive <= 1'b1;
                     sram_wdata <= sel_wdata_c;
                     SRAM_UB_N  <= ~sel_be_c[1];
                     SRAM_LB_N  <= ~sel_be_c[0];
                     SRAM_WE_N  <= (ACC_LAST != ACC_ONE);
                  end else begin
                     SRAM_OE_N  <= 1'b0;
                     sram_drive <= 1'b0;
                     SRAM_UB_N  <= 1'b0;
                     SRAM_LB_N  <= 1'b0;
                     SRAM_WE_N  <= 1'b1;
                  end
               end else begin
                  sram_drive <= 1'b0;
                  SRAM_CE_N  <= 1'b1;
                  SRAM_OE_N  <= 1'b1;
                  SRAM_WE_N  <= 1'b1;
                  SRAM_UB_N  <= 1'b1;
                  SRAM_LB_N  <= 1'b1;
               end
            end
            ACCESS: begin
               if (acc_cnt == ACC_LAST) begin
                  state <= DONE;
                  if (!we_q) begin
                     if (port_q) rdata1 <= sram_rdata;
                     else        rdata0 <= sram_rdata;
                  end
                  if (port_q) ack1 <= 1'b1;
                  else        ack0 <= 1'b1;
                  SRAM_CE_N <= 1'b1;
                  SRAM_OE_N <= 1'b1;
                  SRAM_WE_N <= 1'b1;
                  SRAM_UB_N <= 1'b1;
                  SRAM_LB_N <= 1'b1;
               end else begin
                  acc_cnt   <= acc_cnt + ACC_ONE;
                  SRAM_WE_N <= !(we_q && (acc_cnt + ACC_ONE == ACC_LAST));
               end
            end
            DONE: begin
               state      <= IDLE;
               sram_drive <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: instance a (2 access cycles, MAX_WAIT 4), instance b (1 access cycle).
`timescale 1ns/1ps
module tb_sram_arbiter;

   logic        Clk = 1'b0;
   logic        reset_n;
   logic        req0, we0, req1, we1;
   logic [19:0] addr0, addr1;
   logic [15:0] wdata0, wdata1, sram_rdata;
   logic [1:0]  be0, be1;

   logic        a_ack0, a_ack1, a_drive, a_ce, a_oe, a_we, a_ub, a_lb;
   logic [15:0] a_rdata0, a_rdata1, a_wdata;
   logic [19:0] a_addr;
   logic        b_ack0, b_ack1, b_drive, b_ce, b_oe, b_we, b_ub, b_lb;
   logic [15:0] b_rdata0, b_rdata1, b_wdata;
   logic [19:0] b_addr;
   logic [5:0]  a_ctl, b_ctl;

   int total = 0;
   int bad   = 0;

   // control bundle {CE_N, OE_N, WE_N, UB_N, LB_N, drive}
   assign a_ctl = {a_ce, a_oe, a_we, a_ub, a_lb, a_drive};
   assign b_ctl = {b_ce, b_oe, b_we, b_ub, b_lb, b_drive};

   always #10 Clk = ~Clk;

   sram_arbiter #(.ADDR_W(20), .ACCESS_CYCLES(2), .MAX_WAIT(4)) u_a (
      .Clk(Clk), .reset_n(reset_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .be0(be0),
      .ack0(a_ack0), .rdata0(a_rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .be1(be1),
      .ack1(a_ack1), .rdata1(a_rdata1),
      .sram_rdata(sram_rdata), .sram_wdata(a_wdata), .sram_drive(a_drive),
      .SRAM_ADDR(a_addr), .SRAM_CE_N(a_ce), .SRAM_OE_N(a_oe), .SRAM_WE_N(a_we),
      .SRAM_UB_N(a_ub), .SRAM_LB_N(a_lb)
   );

   sram_arbiter #(.ADDR_W(20), .ACCESS_CYCLES(1), .MAX_WAIT(16)) u_b (
      .Clk(Clk), .reset_n(reset_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .be0(be0),
      .ack0(b_ack0), .rdata0(b_rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .be1(be1),
      .ack1(b_ack1), .rdata1(b_rdata1),
      .sram_rdata(sram_rdata), .sram_wdata(b_wdata), .sram_drive(b_drive),
      .SRAM_ADDR(b_addr), .SRAM_CE_N(b_ce), .SRAM_OE_N(b_oe), .SRAM_WE_N(b_we),
      .SRAM_UB_N(b_ub), .SRAM_LB_N(b_lb)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic clear_inputs();
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; be1 = '0;
      sram_rdata = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic stray;
      clear_inputs();
      reset_n = 1'b0;
      repeat (3) @(negedge Clk);

      // reset values
      chk("rst ctl",    32'(a_ctl), 32'h3E);
      chk("rst addr",   32'(a_addr), 32'h0);
      chk("rst wdata",  32'(a_wdata), 32'h0);
      chk("rst rdata",  32'({a_rdata0, a_rdata1}), 32'h0);
      chk("rst acks",   32'({a_ack0, a_ack1}), 32'h0);
      reset_n = 1'b1;

      // idle after reset
      for (int i = 0; i < 20; i++) begin
         step();
         chk("idle", 32'({a_ctl, a_ack0, a_ack1}), 32'({6'h3E, 2'b00}));
      end

      // single read on port 0
      req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00123; sram_rdata = 16'hBEEF;
      step();
      chk("rd t1 ctl",  32'(a_ctl), 32'h08);
      chk("rd t1 addr", 32'(a_addr), 32'h00123);
      chk("rd t1 ack",  32'(a_ack0), 32'h0);
      step();
      chk("rd t2 ctl",  32'(a_ctl), 32'h08);
      chk("rd t2 ack",  32'(a_ack0), 32'h0);
      step();
      chk("rd t3 ack",  32'(a_ack0), 32'h1);
      chk("rd t3 data", 32'(a_rdata0), 32'hBEEF);
      chk("rd t3 ctl",  32'(a_ctl), 32'h3E);
      req0 = 1'b0;
      step();
      chk("rd t4 ack",  32'(a_ack0), 32'h0);
      chk("rd t4 hold", 32'(a_rdata0), 32'hBEEF);

      // lower-byte write on port 1 at the top address
      clear_inputs();
      do_reset();
      req1 = 1'b1; we1 = 1'b1; addr1 = 20'hFFFFF; wdata1 = 16'h12AB; be1 = 2'b01;
      step();
      chk("wr t1 ctl",   32'(a_ctl), 32'h1D);
      chk("wr t1 addr",  32'(a_addr), 32'hFFFFF);
      chk("wr t1 data",  32'(a_wdata), 32'h12AB);
      chk("wr t1 ack",   32'(a_ack1), 32'h0);
      step();
      chk("wr t2 ctl",   32'(a_ctl), 32'h15);
      step();
      chk("wr t3 ack",   32'(a_ack1), 32'h1);
      chk("wr t3 ctl",   32'(a_ctl), 32'h3F);
      chk("wr t3 addr",  32'(a_addr), 32'hFFFFF);
      chk("wr t3 data",  32'(a_wdata), 32'h12AB);
      req1 = 1'b0;
      step();
      chk("wr t4 ctl",   32'(a_ctl), 32'h3E);
      chk("wr t4 ack",   32'(a_ack1), 32'h0);

      // contention with MAX_WAIT 4: grants alternate 0,1,0,1 with a 4-cycle transaction
      clear_inputs();
      do_reset();
      req0 = 1'b1; addr0 = 20'h00010; req1 = 1'b1; addr1 = 20'h00020; sram_rdata = 16'h5A5A;
      for (int i = 1; i <= 24; i++) begin
         step();
         chk("cont ack0", 32'(a_ack0), 32'((i % 8) == 3));
         chk("cont ack1", 32'(a_ack1), 32'((i % 8) == 7));
         if (i == 7) chk("cont rdata1", 32'(a_rdata1), 32'h5A5A);
      end
      req0 = 1'b0; req1 = 1'b0;
      step();
      step();

      // reset during the second access cycle of a write
      clear_inputs();
      do_reset();
      req0 = 1'b1; we0 = 1'b1; addr0 = 20'h00055; wdata0 = 16'hA5A5; be0 = 2'b11;
      step();
      step();
      chk("mr t2 ctl", 32'(a_ctl), 32'h11);
      #2 reset_n = 1'b0;
      #1;
      chk("mr ctl",  32'(a_ctl), 32'h3E);
      chk("mr ack",  32'(a_ack0), 32'h0);
      chk("mr addr", 32'(a_addr), 32'h0);
      req0 = 1'b0;
      @(negedge Clk);
      reset_n = 1'b1;
      stray = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         stray = stray | a_ack0 | a_ack1;
      end
      chk("mr no ack", 32'(stray), 32'h0);
      req1 = 1'b1; we1 = 1'b0; addr1 = 20'h00042; sram_rdata = 16'h1234;
      step();
      step();
      step();
      chk("mr next ack",  32'({a_ack0, a_ack1}), 32'h1);
      chk("mr next data", 32'(a_rdata1), 32'h1234);
      req1 = 1'b0;
      step();

      // single-cycle access instance: read
      clear_inputs();
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00777; sram_rdata = 16'hC0DE;
      step();
      chk("b rd t1 ctl",  32'(b_ctl), 32'h08);
      chk("b rd t1 addr", 32'(b_addr), 32'h00777);
      chk("b rd t1 ack",  32'(b_ack0), 32'h0);
      step();
      chk("b rd t2 ack",  32'(b_ack0), 32'h1);
      chk("b rd t2 data", 32'(b_rdata0), 32'hC0DE);
      chk("b rd t2 ctl",  32'(b_ctl), 32'h3E);
      req0 = 1'b0;
      step();
      chk("b rd t3 ack",  32'(b_ack0), 32'h0);

      // single-cycle access instance: upper-byte write, WE_N low in its only access cycle
      clear_inputs();
      do_reset();
      req1 = 1'b1; we1 = 1'b1; addr1 = 20'h00009; wdata1 = 16'h0F0F; be1 = 2'b10;
      step();
      chk("b wr t1 ctl",  32'(b_ctl), 32'h13);
      chk("b wr t1 data", 32'(b_wdata), 32'h0F0F);
      step();
      chk("b wr t2 ack",  32'(b_ack1), 32'h1);
      chk("b wr t2 ctl",  32'(b_ctl), 32'h3F);
      req1 = 1'b0;
      step();
      chk("b wr t3 ctl",  32'(b_ctl), 32'h3E);
      chk("b wr t3 ack",  32'(b_ack1), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
